// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the byte-serialising memory arbiter.
package mem_arbiter_pkg;

    // Controller states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Access size codes as presented on mem_size
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef logic [1:0] size_t;

    typedef enum logic {
        OWNER_IF  = 1'b0,
        OWNER_MEM = 1'b1
    } owner_t;

    // Index of the final byte of an access; the unused code 11 behaves as a word
    function automatic logic [1:0] last_byte(input size_t size);
        case (size)
            SIZE_B:  return 2'd0;
            SIZE_H:  return 2'd1;
            SIZE_W:  return 2'd3;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response and RAM-pin bundle around the memory arbiter.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic              rdy;
    // instruction fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [31:0]       if_data;
    // load/store port
    logic              mem_req;
    logic              mem_we;
    size_t             mem_size;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_done;
    logic [31:0]       mem_rdata;
    // byte-wide RAM pins
    logic [ADDR_W-1:0] ram_a;
    logic              ram_wr;
    logic [7:0]        ram_dout;
    logic [7:0]        ram_din;

    // Arbiter side
    modport slave (
        input  rdy, if_req, if_addr, mem_req, mem_we, mem_size, mem_addr, mem_wdata, ram_din,
        output if_done, if_data, mem_done, mem_rdata, ram_a, ram_wr, ram_dout
    );

    // Requesters plus RAM side
    modport master (
        output rdy, if_req, if_addr, mem_req, mem_we, mem_size, mem_addr, mem_wdata, ram_din,
        input  if_done, if_data, mem_done, mem_rdata, ram_a, ram_wr, ram_dout
    );

endinterface

// File: rtl/mem_arbiter.sv
// Shares one byte-wide RAM port between instruction fetch and the MEM stage,
// splitting 1/2/4-byte little-endian accesses into per-byte RAM cycles.
// The RAM is assumed to be stalled by the same rdy, so ram_din keeps the
// byte of the last address it accepted while rdy is low.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter bit MEM_PRIO = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    logic [1:0]        state_reg;
    owner_t            owner_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [1:0]        last_reg;
    logic [1:0]        cnt_reg;
    logic              tail_reg;   // RD: all addresses issued, last byte still in flight
    logic [31:0]       wdata_reg;
    logic [31:0]       buf_reg;

    logic [ADDR_W-1:0] ram_a_reg;
    logic              ram_wr_reg;
    logic [7:0]        ram_dout_reg;
    logic              if_done_reg;
    logic              mem_done_reg;
    logic [31:0]       if_data_reg;
    logic [31:0]       mem_rdata_reg;

    logic              grant_mem;
    logic              grant_if;
    logic [1:0]        cnt_inc;
    logic [ADDR_W-1:0] addr_step;
    logic [7:0]        wbyte_next;
    logic              cap_en;
    logic [1:0]        cap_idx;
    logic [31:0]       buf_next;

    // Pick the winner of the IDLE arbitration
    always_comb begin
        grant_mem = bus.mem_req && (MEM_PRIO || !bus.if_req);
        grant_if  = bus.if_req && !grant_mem;
    end

    assign cnt_inc    = cnt_reg + 2'd1;
    assign addr_step  = addr_reg + ADDR_W'(cnt_inc);
    assign wbyte_next = wdata_reg[{cnt_inc, 3'b000} +: 8];

    // ram_din carries the byte addressed in the previous cycle: byte cnt-1
    // while addresses are still going out, the final byte in the tail cycle.
    assign cap_en  = tail_reg || (cnt_reg != 2'd0);
    assign cap_idx = tail_reg ? last_reg : cnt_reg - 2'd1;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign buf_next[8*gi +: 8] = (cap_en && cap_idx == 2'(gi)) ? bus.ram_din
                                                                    : buf_reg[8*gi +: 8];
    end

    // Arbitration, byte sequencing and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            owner_reg     <= OWNER_IF;
            addr_reg      <= '0;
            last_reg      <= 2'd0;
            cnt_reg       <= 2'd0;
            tail_reg      <= 1'b0;
            wdata_reg     <= 32'd0;
            buf_reg       <= 32'd0;
            ram_a_reg     <= '0;
            ram_wr_reg    <= 1'b0;
            ram_dout_reg  <= 8'd0;
            if_done_reg   <= 1'b0;
            mem_done_reg  <= 1'b0;
            if_data_reg   <= 32'd0;
            mem_rdata_reg <= 32'd0;
        end else if (bus.rdy) begin
            if_done_reg  <= 1'b0;
            mem_done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (grant_mem || grant_if) begin
                        owner_reg <= grant_mem ? OWNER_MEM : OWNER_IF;
                        addr_reg  <= grant_mem ? bus.mem_addr : bus.if_addr;
                        ram_a_reg <= grant_mem ? bus.mem_addr : bus.if_addr;
                        last_reg  <= grant_mem ? last_byte(bus.mem_size) : 2'd3;
                        wdata_reg <= bus.mem_wdata;
                        cnt_reg   <= 2'd0;
                        tail_reg  <= 1'b0;
                        buf_reg   <= 32'd0;   // zero upper bytes of short loads
                        if (grant_mem && bus.mem_we) begin
                            state_reg    <= ST_WR;
                            ram_wr_reg   <= 1'b1;
                            ram_dout_reg <= bus.mem_wdata[7:0];
                        end else begin
                            state_reg <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (owner_reg == OWNER_IF && !bus.if_req) begin
                        // fetch flushed: drop the read without a response
                        state_reg <= ST_IDLE;
                        ram_a_reg <= '0;
                        tail_reg  <= 1'b0;
                    end else begin
                        buf_reg <= buf_next;
                        if (tail_reg) begin
                            state_reg <= ST_DONE;
                            tail_reg  <= 1'b0;
                            if (owner_reg == OWNER_IF) begin
                                if_done_reg <= 1'b1;
                                if_data_reg <= buf_next;
                            end else begin
                                mem_done_reg  <= 1'b1;
                                mem_rdata_reg <= buf_next;
                            end
                        end else if (cnt_reg == last_reg) begin
                            tail_reg  <= 1'b1;
                            ram_a_reg <= '0;
                        end else begin
                            cnt_reg   <= cnt_inc;
                            ram_a_reg <= addr_step;
                        end
                    end
                end
                ST_WR: begin
                    if (cnt_reg == last_reg) begin
                        state_reg    <= ST_DONE;
                        ram_wr_reg   <= 1'b0;
                        ram_a_reg    <= '0;
                        ram_dout_reg <= 8'd0;
                        mem_done_reg <= 1'b1;
                    end else begin
                        cnt_reg      <= cnt_inc;
                        ram_a_reg    <= addr_step;
                        ram_dout_reg <= wbyte_next;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // A low rdy suppresses the write strobe and defers any done pulse
    assign bus.ram_a     = ram_a_reg;
    assign bus.ram_wr    = ram_wr_reg && bus.rdy;
    assign bus.ram_dout  = ram_dout_reg;
    assign bus.if_done   = if_done_reg && bus.rdy;
    assign bus.if_data   = if_data_reg;
    assign bus.mem_done  = mem_done_reg && bus.rdy;
    assign bus.mem_rdata = mem_rdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios then randomized traffic.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   tests_run = 0;
    int   tests_failed = 0;
    int   cyc = 0;
    bit   rand_rdy = 1'b0;

    mem_arbiter_if #(.ADDR_W(32)) bus ();
    mem_arbiter #(.ADDR_W(32), .MEM_PRIO(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { bit is_load; logic [31:0] data; } mem_exp_t;
    logic [31:0] if_q [$];
    mem_exp_t    mem_q [$];
    logic [39:0] wr_q [$];          // {address, byte} of each expected RAM write
    logic [7:0]  ram_mem [256];     // physical RAM, aliased on the low address byte
    logic [7:0]  ref_mem [256];     // reference model memory, same aliasing
    logic [31:0] if_trace [16];
    logic [31:0] mem_trace [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic flag(input string name, input string what);
        tests_run++;
        tests_failed++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Byte-wide RAM: one-cycle read latency, stalled by rdy like the arbiter
    always @(posedge clk) begin
        if (bus.ram_wr) ram_mem[bus.ram_a[7:0]] <= bus.ram_dout;
        if (bus.rdy) bus.ram_din <= ram_mem[bus.ram_a[7:0]];
    end

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input int n);
        logic [31:0] d = 32'd0;
        logic [31:0] ak;
        for (int k = 0; k < n; k++) begin
            ak = a + 32'(k);
            d[8*k +: 8] = ref_mem[ak[7:0]];
        end
        return d;
    endfunction

    task automatic push_if(input logic [31:0] a);
        if_q.push_back(ref_load(a, 4));
    endtask

    task automatic push_mem(input logic we, input logic [1:0] size, input logic [31:0] a,
                            input logic [31:0] wd);
        logic [31:0] ak;
        mem_exp_t e;
        if (we) begin
            for (int k = 0; k < nbytes(size); k++) begin
                ak = a + 32'(k);
                ref_mem[ak[7:0]] = wd[8*k +: 8];
                wr_q.push_back({ak, wd[8*k +: 8]});
            end
            e.is_load = 1'b0;
            e.data    = 32'd0;
        end else begin
            e.is_load = 1'b1;
            e.data    = ref_load(a, nbytes(size));
        end
        mem_q.push_back(e);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a response or a write
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.if_done && bus.mem_done) flag("dual_done", "both dones high, required one");
            if (bus.if_done) begin
                $display("[TB] if_done  data=%08h", bus.if_data);
                if (if_q.size() == 0) flag("if_done", "pulse seen, required none");
                else check("if_data", bus.if_data, if_q.pop_front());
            end
            if (bus.mem_done) begin
                $display("[TB] mem_done rdata=%08h", bus.mem_rdata);
                if (mem_q.size() == 0) flag("mem_done", "pulse seen, required none");
                else begin
                    mem_exp_t e;
                    e = mem_q.pop_front();
                    if (e.is_load) check("mem_rdata", bus.mem_rdata, e.data);
                end
            end
            if (bus.ram_wr) begin
                $display("[TB] ram_wr   a=%08h d=%02h", bus.ram_a, bus.ram_dout);
                if (!bus.rdy) flag("wr_stall", "ram_wr=1 with rdy=0, required 0");
                if (wr_q.size() == 0) flag("ram_write", "write seen, required none");
                else check("ram_write", {bus.ram_a, bus.ram_dout}, wr_q.pop_front());
            end
        end
    end

    // Requesters: called just after a posedge; done_rel counts cycles from the call
    task automatic if_txn(input logic [31:0] a, input int drop_at, input int budget,
                          output int done_rel);
        int start;
        start = cyc;
        done_rel = -1;
        bus.if_addr = a;
        bus.if_req  = 1'b1;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (n < 16) if_trace[n] = bus.ram_a;
            if (bus.if_done) begin
                done_rel = cyc - start;
                break;
            end
            if (n + 1 == drop_at) begin
                @(posedge clk); #1;
                bus.if_req = 1'b0;
                return;
            end
        end
        if (done_rel < 0) flag("if_timeout", $sformatf("no if_done in %0d cycles", budget));
        @(posedge clk); #1;
        bus.if_req = 1'b0;
    endtask

    task automatic mem_txn(input logic we, input logic [1:0] size, input logic [31:0] a,
                           input logic [31:0] wd, input int budget, output int done_rel);
        int start;
        start = cyc;
        done_rel = -1;
        bus.mem_we = we;  bus.mem_size = size;  bus.mem_addr = a;  bus.mem_wdata = wd;
        bus.mem_req = 1'b1;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (n < 16) mem_trace[n] = bus.ram_a;
            if (bus.mem_done) begin
                done_rel = cyc - start;
                break;
            end
        end
        if (done_rel < 0) flag("mem_timeout", $sformatf("no mem_done in %0d cycles", budget));
        @(posedge clk); #1;
        bus.mem_req = 1'b0;
    endtask

    task automatic word_fetch_0x100();
        int d;
        push_if(32'h100);
        if_txn(32'h100, -1, 30, d);
        for (int c = 1; c <= 4; c++) check($sformatf("t1_ram_a_c%0d", c), if_trace[c], 32'h100 + 32'(c - 1));
        check("t1_done_cycle", d, 6);
    endtask

    function automatic logic [31:0] rand_addr();
        return ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                            : 32'($urandom_range(0, 255));
    endfunction

    // Random stall generator, active only during the random phase
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_rdy) bus.rdy = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d1, d2, mode;
        logic [31:0] a, a2, wd;
        logic we;
        logic [1:0] sz;

        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = 8'(i) ^ 8'hA5;
            ref_mem[i] = 8'(i) ^ 8'hA5;
        end
        ram_mem[8'h00] = 8'h11; ram_mem[8'h01] = 8'h22; ram_mem[8'h02] = 8'h33; ram_mem[8'h03] = 8'h44;
        ref_mem[8'h00] = 8'h11; ref_mem[8'h01] = 8'h22; ref_mem[8'h02] = 8'h33; ref_mem[8'h03] = 8'h44;

        rst = 1'b1;
        bus.rdy = 1'b1;  bus.if_req = 1'b0;  bus.if_addr = 32'd0;
        bus.mem_req = 1'b0;  bus.mem_we = 1'b0;  bus.mem_size = 2'b00;
        bus.mem_addr = 32'd0;  bus.mem_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_ram_a", bus.ram_a, 0);
        check("reset_ram_wr", bus.ram_wr, 0);
        check("reset_dones", {bus.if_done, bus.mem_done}, 0);
        check("reset_data", {bus.if_data, bus.mem_rdata}, 0);
        @(posedge clk); #1;

        // Word fetch with latency and address sequence
        word_fetch_0x100();

        // Half-word store: two writes then done
        push_mem(1'b1, 2'b01, 32'h20, 32'hAABBCCDD);
        mem_txn(1'b1, 2'b01, 32'h20, 32'hAABBCCDD, 30, d1);
        check("t2_done_cycle", d1, 3);
        check("t2_writes_left", wr_q.size(), 0);

        // Simultaneous requests: MEM first, IF right after the following IDLE
        push_mem(1'b0, 2'b10, 32'h100, 32'd0);
        push_if(32'h20);
        fork
            if_txn(32'h20, -1, 40, d1);
            mem_txn(1'b0, 2'b10, 32'h100, 32'd0, 40, d2);
        join
        check("t3_mem_done_cycle", d2, 6);
        check("t3_if_done_cycle", d1, 13);

        // Fetch flushed in cycle 2; the pending byte load is granted at once
        push_mem(1'b0, 2'b00, 32'h100, 32'd0);
        fork
            if_txn(32'h200, 2, 40, d1);
            begin
                @(posedge clk); #1;
                mem_txn(1'b0, 2'b00, 32'h100, 32'd0, 40, d2);
            end
        join
        check("t4_mem_done_cycle", d2, 5);

        // rdy low for cycles 2..4 of a word store
        push_mem(1'b1, 2'b10, 32'h40, 32'h01020304);
        fork
            mem_txn(1'b1, 2'b10, 32'h40, 32'h01020304, 40, d1);
            begin
                repeat (2) @(posedge clk);
                #1 bus.rdy = 1'b0;
                repeat (3) @(posedge clk);
                #1 bus.rdy = 1'b1;
            end
        join
        check("t5_done_cycle", d1, 8);
        for (int c = 2; c <= 5; c++) check($sformatf("t5_ram_a_c%0d", c), mem_trace[c], 32'h41);
        check("t5_ram_a_c6", mem_trace[6], 32'h42);

        // Asynchronous reset in the middle of a word load
        bus.mem_we = 1'b0;  bus.mem_size = 2'b10;  bus.mem_addr = 32'h300;
        bus.mem_req = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6_ram_a", bus.ram_a, 0);
        check("t6_ram_wr_dout", {bus.ram_wr, bus.ram_dout}, 0);
        check("t6_dones", {bus.if_done, bus.mem_done}, 0);
        check("t6_data", {bus.if_data, bus.mem_rdata}, 0);
        bus.mem_req = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        word_fetch_0x100();

        // Randomized traffic with random stalls
        rand_rdy = 1'b1;
        for (int it = 0; it < 60; it++) begin
            mode = $urandom_range(0, 3);
            a  = rand_addr();
            a2 = rand_addr();
            we = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            wd = $urandom;
            case (mode)
                0: begin
                    push_if(a);
                    if_txn(a, -1, 200, d1);
                end
                1: begin
                    push_mem(we, sz, a2, wd);
                    mem_txn(we, sz, a2, wd, 200, d2);
                end
                2: begin
                    push_mem(we, sz, a2, wd);   // MEM wins, so its effect comes first
                    push_if(a);
                    fork
                        if_txn(a, -1, 300, d1);
                        mem_txn(we, sz, a2, wd, 300, d2);
                    join
                end
                default: begin
                    if_txn(a, $urandom_range(1, 3), 200, d1);
                    for (int k = 0; k < 50; k++) begin
                        @(posedge clk);
                        if (bus.rdy) break;
                    end
                    #1;
                end
            endcase
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        rand_rdy = 1'b0;
        @(posedge clk); #2 bus.rdy = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("end_if_q", if_q.size(), 0);
        check("end_mem_q", mem_q.size(), 0);
        check("end_wr_q", wr_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
